// File: rtl/if_fetch_ctrl_pkg.sv
// Shared FSM encoding, PC-select codes and widths for the fetch sequencing controller.
package if_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    EXC  = 2'd2
  } fetchState_e;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_JMP = 2'd2;
  localparam logic [1:0] PCSEL_EXC = 2'd3;

  localparam int CAUSE_W = 4;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Request/control bundle between the pipeline and the fetch sequencing controller.
interface if_fetch_ctrl_if;
  import if_pkg::*;

  logic [31:0]        pc_current;
  logic               stall_req;
  logic               p2_isBranch;
  logic               p2_alu_flag_N;
  logic               isJump;
  logic               isException;
  logic [CAUSE_W-1:0] exc_cause;
  logic               exc_ret;
  logic               imem_ready;

  logic               pcWrite;
  logic [1:0]         pc_sel;
  logic               p1_pipeline_regWrite;
  logic               p1_flush;
  logic [31:0]        epc;
  logic [CAUSE_W-1:0] cause;
  logic               exc_active;

  modport master (
    output pc_current, stall_req, p2_isBranch, p2_alu_flag_N, isJump,
           isException, exc_cause, exc_ret, imem_ready,
    input  pcWrite, pc_sel, p1_pipeline_regWrite, p1_flush, epc, cause, exc_active
  );

  modport slave (
    input  pc_current, stall_req, p2_isBranch, p2_alu_flag_N, isJump,
           isException, exc_cause, exc_ret, imem_ready,
    output pcWrite, pc_sel, p1_pipeline_regWrite, p1_flush, epc, cause, exc_active
  );

endinterface

// File: rtl/if_fetch_ctrl_perf.sv
// Free-running stall and redirect event counters for the fetch controller (IF_FETCH_CTRL_PERF_EN builds).
module if_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallEvt,
  input  logic        redirectEvt,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
);

  // Both counters simply wrap; software samples deltas.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (stallEvt)    stall_cycles   <= stall_cycles + 32'd1;
      if (redirectEvt) redirect_count <= redirect_count + 32'd1;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: reset hold-off, exception entry, redirect, stall and memory wait.
// Optional IF_FETCH_CTRL_PERF_EN adds stall_cycles / redirect_count outputs.
import if_pkg::*;

module if_fetch_ctrl #(
  parameter int RESET_HOLD = 2,
  parameter int EXC_FLUSH  = 2
) (
  input logic clk,
  input logic reset,
  if_fetch_ctrl_if.slave bus
`ifdef IF_FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
`endif
);

  localparam logic [1:0] ST_HOLD = HOLD;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_EXC  = EXC;

  localparam int CNT_W = $clog2(maxOf(RESET_HOLD, EXC_FLUSH)) + 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] EXC_INIT  = CNT_W'(EXC_FLUSH - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        epcQ;
  logic [CAUSE_W-1:0] causeQ;
  logic               excActive;

  logic               pcWriteC;
  logic [1:0]         pcSelC;
  logic               regWriteC;
  logic               flushC;
  logic               excTake;

  // Mealy decode; the default is the quiet flushing profile used by HOLD and reset.
  always_comb begin
    pcWriteC  = 1'b0;
    pcSelC    = PCSEL_SEQ;
    regWriteC = 1'b0;
    flushC    = 1'b1;
    excTake   = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.isException && !excActive) begin
          excTake  = 1'b1;
          pcSelC   = PCSEL_EXC;
          pcWriteC = 1'b1;
        end else if (bus.isJump || (bus.p2_isBranch && bus.p2_alu_flag_N)) begin
          pcSelC   = bus.isJump ? PCSEL_JMP : PCSEL_BR;
          pcWriteC = 1'b1;
        end else if (bus.stall_req || !bus.imem_ready) begin
          // A decode stall keeps the held instruction; a pure memory wait injects a bubble.
          flushC = !bus.stall_req;
        end else begin
          pcWriteC  = 1'b1;
          regWriteC = 1'b1;
          flushC    = 1'b0;
        end
      end
      ST_EXC: begin
        pcWriteC = bus.imem_ready;
      end
      default: ;
    endcase
  end

  // State, hold-off counter and exception capture; exc_ret only clears when no new entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_HOLD;
      cnt       <= HOLD_INIT;
      epcQ      <= '0;
      causeQ    <= '0;
      excActive <= 1'b0;
    end else begin
      case (state)
        ST_HOLD, ST_EXC: begin
          if (cnt == '0) state <= ST_RUN;
          else           cnt   <= cnt - CNT_W'(1);
        end
        ST_RUN: begin
          if (excTake) begin
            state <= ST_EXC;
            cnt   <= EXC_INIT;
          end
        end
        default: state <= ST_HOLD;
      endcase
      if (excTake) begin
        epcQ      <= bus.pc_current;
        causeQ    <= bus.exc_cause;
        excActive <= 1'b1;
      end else if (bus.exc_ret) begin
        excActive <= 1'b0;
      end
    end
  end

  assign bus.pcWrite              = pcWriteC;
  assign bus.pc_sel               = pcSelC;
  assign bus.p1_pipeline_regWrite = regWriteC;
  assign bus.p1_flush             = flushC;
  assign bus.epc                  = epcQ;
  assign bus.cause                = causeQ;
  assign bus.exc_active           = excActive;

`ifdef IF_FETCH_CTRL_PERF_EN
  // In RUN, a withheld PC write is a stall and any non-sequential write is a redirect or entry.
  if_perf_counters perf (
    .clk            (clk),
    .reset          (reset),
    .stallEvt       (state == ST_RUN && !pcWriteC),
    .redirectEvt    (state == ST_RUN && pcWriteC && pcSelC != PCSEL_SEQ),
    .stall_cycles   (stall_cycles),
    .redirect_count (redirect_count)
  );
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed plan items plus randomized traffic against a cycle-count model.
module tb_if_fetch_ctrl;

  localparam int RESET_HOLD = 2;
  localparam int EXC_FLUSH  = 2;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   checkEn = 0;

  if_fetch_ctrl_if bus ();

`ifdef IF_FETCH_CTRL_PERF_EN
  logic [31:0] stallCycles;
  logic [31:0] redirectCount;
  logic [31:0] mStall;
  logic [31:0] mRedir;
`endif

  if_fetch_ctrl #(
    .RESET_HOLD (RESET_HOLD),
    .EXC_FLUSH  (EXC_FLUSH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IF_FETCH_CTRL_PERF_EN
    ,
    .stall_cycles   (stallCycles),
    .redirect_count (redirectCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: remaining blocked cycles after reset, remaining handler-flush cycles, captured exception.
  int          holdLeft;
  int          flushLeft;
  logic        mActive;
  logic [31:0] mEpc;
  logic [3:0]  mCause;

  typedef struct packed {
    logic       pw;
    logic [1:0] sel;
    logic       rw;
    logic       fl;
  } ctl_t;

  function automatic bit takeNow();
    return holdLeft == 0 && flushLeft == 0 && bus.isException && !mActive;
  endfunction

  function automatic ctl_t expectedCtl();
    ctl_t e;
    e = '{pw: 1'b0, sel: 2'd0, rw: 1'b0, fl: 1'b1};
    if (!reset || holdLeft > 0) return e;
    if (flushLeft > 0) begin
      e.pw = bus.imem_ready;
      return e;
    end
    if (takeNow()) begin
      e.pw = 1'b1; e.sel = 2'd3;
    end else if (bus.isJump) begin
      e.pw = 1'b1; e.sel = 2'd2;
    end else if (bus.p2_isBranch && bus.p2_alu_flag_N) begin
      e.pw = 1'b1; e.sel = 2'd1;
    end else if (bus.stall_req) begin
      e.fl = 1'b0;
    end else if (bus.imem_ready) begin
      e.pw = 1'b1; e.rw = 1'b1; e.fl = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      holdLeft  <= RESET_HOLD;
      flushLeft <= 0;
      mActive   <= 1'b0;
      mEpc      <= '0;
      mCause    <= '0;
`ifdef IF_FETCH_CTRL_PERF_EN
      mStall    <= '0;
      mRedir    <= '0;
`endif
    end else begin
`ifdef IF_FETCH_CTRL_PERF_EN
      if (holdLeft == 0 && flushLeft == 0) begin
        if (!expectedCtl().pw)            mStall <= mStall + 32'd1;
        else if (expectedCtl().sel != 2'd0) mRedir <= mRedir + 32'd1;
      end
`endif
      if (holdLeft > 0)       holdLeft  <= holdLeft - 1;
      else if (flushLeft > 0) flushLeft <= flushLeft - 1;
      else if (takeNow())     flushLeft <= EXC_FLUSH;
      if (takeNow()) begin
        mEpc    <= bus.pc_current;
        mCause  <= bus.exc_cause;
        mActive <= 1'b1;
      end else if (bus.exc_ret) begin
        mActive <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every mid-cycle point compares all outputs to the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("pcWrite",  32'(bus.pcWrite),              32'(expectedCtl().pw));
      checkOutput("pc_sel",   32'(bus.pc_sel),               32'(expectedCtl().sel));
      checkOutput("regWrite", 32'(bus.p1_pipeline_regWrite), 32'(expectedCtl().rw));
      checkOutput("flush",    32'(bus.p1_flush),             32'(expectedCtl().fl));
      checkOutput("epc",      bus.epc,                       mEpc);
      checkOutput("cause",    32'(bus.cause),                32'(mCause));
      checkOutput("excActive",32'(bus.exc_active),           32'(mActive));
`ifdef IF_FETCH_CTRL_PERF_EN
      checkOutput("stallCycles",   stallCycles,   mStall);
      checkOutput("redirectCount", redirectCount, mRedir);
`endif
    end
  end

  task automatic applyStimulus(input logic [31:0] pc, input logic stall, input logic br,
                               input logic flagN, input logic jmp, input logic exc,
                               input logic [3:0] excCause, input logic ret, input logic ready);
    bus.pc_current    = pc;
    bus.stall_req     = stall;
    bus.p2_isBranch   = br;
    bus.p2_alu_flag_N = flagN;
    bus.isJump        = jmp;
    bus.isException   = exc;
    bus.exc_cause     = excCause;
    bus.exc_ret       = ret;
    bus.imem_ready    = ready;
  endtask

  task automatic idle(input logic [31:0] pc);
    applyStimulus(pc, 0, 0, 0, 0, 0, 4'd0, 0, 1);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle(32'h0);
    repeat (2) @(posedge clk);
    #1;
    checkEn = 1;
    @(negedge clk);
    checkOutput("rstPcWrite", 32'(bus.pcWrite), 32'd0);
    checkOutput("rstFlush",   32'(bus.p1_flush), 32'd1);

    // Reset release: two held cycles, then the first sequential fetch.
    nextCycle(); reset = 1'b1;
    @(negedge clk);
    checkOutput("hold1PcWrite", 32'(bus.pcWrite), 32'd0);
    checkOutput("hold1Flush",   32'(bus.p1_flush), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("hold2PcWrite", 32'(bus.pcWrite), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("fetchPcWrite", 32'(bus.pcWrite), 32'd1);
    checkOutput("fetchPcSel",   32'(bus.pc_sel),  32'd0);

    // Taken branch overrides a decode stall; untaken branch leaves the stall.
    nextCycle(); applyStimulus(32'h10, 1, 1, 1, 0, 0, 4'd0, 0, 1);
    @(negedge clk);
    checkOutput("brPcSel",   32'(bus.pc_sel),   32'd1);
    checkOutput("brPcWrite", 32'(bus.pcWrite),  32'd1);
    checkOutput("brFlush",   32'(bus.p1_flush), 32'd1);
    nextCycle(); applyStimulus(32'h14, 1, 1, 0, 0, 0, 4'd0, 0, 1);
    @(negedge clk);
    checkOutput("brStallPcWrite", 32'(bus.pcWrite), 32'd0);

    // Exception entry and handler flush window.
    nextCycle(); applyStimulus(32'h40, 0, 0, 0, 0, 1, 4'd5, 0, 1);
    @(negedge clk);
    checkOutput("excPcSel", 32'(bus.pc_sel), 32'd3);
    nextCycle(); idle(32'h44);
    @(negedge clk);
    checkOutput("excEpc",    bus.epc,               32'h40);
    checkOutput("excCause",  32'(bus.cause),        32'd5);
    checkOutput("excActive", 32'(bus.exc_active),   32'd1);
    checkOutput("excFlush1", 32'(bus.p1_flush),     32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("excFlush2", 32'(bus.p1_flush), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("excDoneFlush", 32'(bus.p1_flush), 32'd0);

    // Nested exception is dropped; after exc_ret a new one is captured.
    nextCycle(); applyStimulus(32'h80, 0, 0, 0, 0, 1, 4'd7, 0, 1);
    @(negedge clk);
    checkOutput("nestedPcSel", 32'(bus.pc_sel), 32'd0);
    nextCycle(); applyStimulus(32'h84, 0, 0, 0, 0, 0, 4'd0, 1, 1);
    @(negedge clk);
    checkOutput("nestedEpc", bus.epc, 32'h40);
    nextCycle(); applyStimulus(32'h80, 0, 0, 0, 0, 1, 4'd7, 0, 1);
    @(negedge clk);
    checkOutput("retActive", 32'(bus.exc_active), 32'd0);
    checkOutput("rePcSel",   32'(bus.pc_sel),     32'd3);
    nextCycle(); idle(32'h200);
    @(negedge clk);
    checkOutput("reEpc",   bus.epc,        32'h80);
    checkOutput("reCause", 32'(bus.cause), 32'd7);
    nextCycle();
    nextCycle(); applyStimulus(32'h208, 0, 0, 0, 0, 0, 4'd0, 1, 1);

    // Memory wait with a jump arriving mid-wait.
    nextCycle(); applyStimulus(32'h20c, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    @(negedge clk);
    checkOutput("memPcWrite",  32'(bus.pcWrite),              32'd0);
    checkOutput("memRegWrite", 32'(bus.p1_pipeline_regWrite), 32'd0);
    checkOutput("memFlush",    32'(bus.p1_flush),             32'd1);
    nextCycle(); applyStimulus(32'h20c, 0, 0, 0, 1, 0, 4'd0, 0, 0);
    @(negedge clk);
    checkOutput("jmpPcSel",   32'(bus.pc_sel),  32'd2);
    checkOutput("jmpPcWrite", 32'(bus.pcWrite), 32'd1);
    nextCycle(); applyStimulus(32'h300, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    @(negedge clk);
    checkOutput("mem3PcWrite", 32'(bus.pcWrite), 32'd0);

    // Asynchronous reset while inside the handler window.
    nextCycle(); applyStimulus(32'h304, 0, 0, 0, 0, 1, 4'd3, 0, 1);
    nextCycle(); idle(32'h400);
    #2 reset = 1'b0;
    #1;
    checkOutput("arstPcWrite",   32'(bus.pcWrite),    32'd0);
    checkOutput("arstFlush",     32'(bus.p1_flush),   32'd1);
    checkOutput("arstExcActive", 32'(bus.exc_active), 32'd0);
    checkOutput("arstEpc",       bus.epc,             32'd0);
`ifdef IF_FETCH_CTRL_PERF_EN
    checkOutput("arstStall", stallCycles,   32'd0);
    checkOutput("arstRedir", redirectCount, 32'd0);
`endif
    nextCycle(); reset = 1'b1;

    // Randomized traffic with rare reset pulses.
    for (int i = 0; i < 3000; i++) begin
      nextCycle();
      reset = ($urandom_range(0, 399) != 0);
      applyStimulus($urandom,
                    $urandom_range(0, 3) == 0,
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) == 0,
                    4'($urandom),
                    $urandom_range(0, 11) == 0,
                    $urandom_range(0, 3) != 0);
    end

    nextCycle();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
